// File: rtl/poly_arith_pkg.sv
// Shared arithmetic definitions for the polynomial coefficient datapath:
// modulus, coefficient type, polynomial length and the scaler FSM states.
package poly_arith;

  localparam int Q       = 3329;
  localparam int N_COEFF = 256;

  typedef logic [11:0] coeff_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    DIV,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/mod_div_by_2.sv
// Combinational halving modulo Q: odd inputs get Q added first so the
// result stays an exact modular inverse-of-two multiply.
module mod_div_by_2
  import poly_arith::*;
(
  input  coeff_t x,
  output coeff_t y
);

  logic [12:0] sum;

  assign sum = x[0] ? ({1'b0, x} + 13'(Q)) : {1'b0, x};
  assign y   = sum[12:1];

endmodule

// File: rtl/poly_scale_ctrl.sv
// Walks the RAM-resident polynomial, multiplying every coefficient by
// 2^-k mod Q via k successive modular halvings, and writes it back in place.
//
// state | meaning
// IDLE  | waiting for start_i
// READ  | read strobe for coefficient idx
// WAIT  | RAM data returns, captured into work_q
// DIV   | one modular halving per cycle, k cycles total
// WRITE | write strobe with scaled coefficient
// DONE  | one-cycle completion pulse
module poly_scale_ctrl
  import poly_arith::*;
#(
  parameter int N_COEFF = poly_arith::N_COEFF,
  parameter int SHIFT_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               abort_i,
  output logic               rd_en_o,
  output logic [7:0]         rd_addr_o,
  input  coeff_t             rd_data_i,
  output logic               wr_en_o,
  output logic [7:0]         wr_addr_o,
  output coeff_t             wr_data_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [7:0] LAST_IDX = 8'(N_COEFF - 1);

  state_t             state;
  logic [7:0]         idx;
  logic [SHIFT_W-1:0] k_q;
  logic [SHIFT_W-1:0] div_cnt;
  coeff_t             work_q;
  coeff_t             half;

  mod_div_by_2 u_div2 (
    .x (work_q),
    .y (half)
  );

  // Read and write share the index because writes go back in place.
  assign rd_addr_o = idx;
  assign wr_addr_o = idx;
  assign wr_data_o = work_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      idx     <= '0;
      k_q     <= '0;
      div_cnt <= '0;
      work_q  <= '0;
      rd_en_o <= 1'b0;
      wr_en_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      rd_en_o <= 1'b0;
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;
      if (abort_i && state != IDLE) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              k_q     <= shift_i;
              idx     <= '0;
              busy_o  <= 1'b1;
              rd_en_o <= 1'b1;
              state   <= READ;
            end
          end
          READ: state <= WAIT;
          WAIT: begin
            work_q  <= rd_data_i;
            div_cnt <= k_q;
            if (k_q != '0) begin
              state <= DIV;
            end else begin
              wr_en_o <= 1'b1;
              state   <= WRITE;
            end
          end
          DIV: begin
            work_q  <= half;
            div_cnt <= div_cnt - 1'b1;
            if (div_cnt == SHIFT_W'(1)) begin
              wr_en_o <= 1'b1;
              state   <= WRITE;
            end
          end
          WRITE: begin
            if (idx == LAST_IDX) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= DONE;
            end else begin
              idx     <= idx + 8'd1;
              rd_en_o <= 1'b1;
              state   <= READ;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
